// File: rtl/buf_ctrl_pkg.sv
// Shared types and constants for the buffer allocation controller.
package buf_ctrl_pkg;

  localparam int unsigned LEN     = 2;
  localparam int unsigned NUM_BUF = 4;

  localparam logic [LEN-1:0] BUF_0 = 2'd0;
  localparam logic [LEN-1:0] BUF_1 = 2'd1;
  localparam logic [LEN-1:0] BUF_2 = 2'd2;
  localparam logic [LEN-1:0] BUF_3 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_EVICT,
    ST_FILL,
    ST_RESP
  } state_t;

endpackage

// File: rtl/buf_tag_store.sv
// Resident-tag store: 4 x {valid, tag} with parallel compare and
// lowest-index hit / lowest-index free selection.
module buf_tag_store #(
  parameter int TAG_W = 8,
  parameter int LEN   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_all,
  input  logic             wr_en,
  input  logic [LEN-1:0]   wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             inv_en,
  input  logic [LEN-1:0]   inv_idx,
  input  logic [TAG_W-1:0] cmp_tag,
  output logic             hit,
  output logic [LEN-1:0]   hit_idx,
  output logic             any_free,
  output logic [LEN-1:0]   free_idx
);
  import buf_ctrl_pkg::*;

  logic [NUM_BUF-1:0] valid_q;
  logic [TAG_W-1:0]   tags_q [NUM_BUF];

  // Valid/tag array update; flush-all overrides any write or invalidate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < NUM_BUF; i++) begin
        tags_q[i] <= '0;
      end
    end else if (flush_all) begin
      valid_q <= '0;
    end else begin
      if (inv_en) begin
        valid_q[inv_idx] <= 1'b0;
      end
      if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
        tags_q[wr_idx]  <= wr_tag;
      end
    end
  end

  // Parallel compare; first match in ascending order gives lowest index.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = BUF_0;
    any_free = 1'b0;
    free_idx = BUF_0;
    for (int unsigned i = 0; i < NUM_BUF; i++) begin
      if (!hit && valid_q[i] && (tags_q[i] == cmp_tag)) begin
        hit     = 1'b1;
        hit_idx = LEN'(i);
      end
      if (!any_free && !valid_q[i]) begin
        any_free = 1'b1;
        free_idx = LEN'(i);
      end
    end
  end

endmodule

// File: rtl/buf_alloc_ctrl.sv
// Allocation controller: resolves tag lookups against the tag store,
// selects a free or LFU victim buffer, and runs the fill handshake.
module buf_alloc_ctrl #(
  parameter int TAG_W = 8,
  parameter int LEN   = 2,
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_ready,
  input  logic             flush,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic             rsp_err,
  output logic [LEN-1:0]   rsp_buf,
  output logic             lfu_new_buf_req,
  output logic             lfu_ref_vld,
  output logic [LEN-1:0]   lfu_ref_buf_numbr,
  input  logic [LEN-1:0]   lfu_buf_num_replc,
  output logic             fill_req,
  output logic [LEN-1:0]   fill_buf,
  output logic [TAG_W-1:0] fill_tag,
  input  logic             fill_done
);
  import buf_ctrl_pkg::*;

  // Last FILL cycle before timeout: the increment here takes the timer to all-ones.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2 ** TMO_W) - 2);

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   tag_q;
  logic [LEN-1:0]     victim_q, victim_d;
  logic               hit_q, hit_d, err_q, err_d;
  logic               flush_pend_q, flush_pend_d;
  logic [TMO_W-1:0]   timer_q;

  logic               tag_ld, victim_ld, flag_ld, timer_clr, timer_inc;
  logic               st_flush, st_wr, st_inv;
  logic               st_hit, st_any_free;
  logic [LEN-1:0]     st_hit_idx, st_free_idx;

  buf_tag_store #(
    .TAG_W (TAG_W),
    .LEN   (LEN)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_all (st_flush),
    .wr_en     (st_wr),
    .wr_idx    (victim_q),
    .wr_tag    (tag_q),
    .inv_en    (st_inv),
    .inv_idx   (lfu_buf_num_replc),
    .cmp_tag   (tag_q),
    .hit       (st_hit),
    .hit_idx   (st_hit_idx),
    .any_free  (st_any_free),
    .free_idx  (st_free_idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, finder/store strobes and register load enables.
  always_comb begin
    state_d           = state_q;
    req_ready         = 1'b0;
    lfu_new_buf_req   = 1'b0;
    lfu_ref_vld       = 1'b0;
    lfu_ref_buf_numbr = '0;
    tag_ld            = 1'b0;
    victim_ld         = 1'b0;
    victim_d          = victim_q;
    flag_ld           = 1'b0;
    hit_d             = 1'b0;
    err_d             = 1'b0;
    timer_clr         = 1'b0;
    timer_inc         = 1'b0;
    st_flush          = 1'b0;
    st_wr             = 1'b0;
    st_inv            = 1'b0;
    flush_pend_d      = flush_pend_q | flush;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = !flush && !flush_pend_q;
        if (flush || flush_pend_q) begin
          st_flush     = 1'b1;
          flush_pend_d = 1'b0;
        end else if (req_valid) begin
          tag_ld  = 1'b1;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (st_hit) begin
          lfu_ref_vld       = 1'b1;
          lfu_ref_buf_numbr = st_hit_idx;
          victim_ld         = 1'b1;
          victim_d          = st_hit_idx;
          flag_ld           = 1'b1;
          hit_d             = 1'b1;
          state_d           = ST_RESP;
        end else if (st_any_free) begin
          victim_ld = 1'b1;
          victim_d  = st_free_idx;
          timer_clr = 1'b1;
          state_d   = ST_FILL;
        end else begin
          lfu_new_buf_req = 1'b1;
          state_d         = ST_EVICT;
        end
      end
      ST_EVICT: begin
        victim_ld = 1'b1;
        victim_d  = lfu_buf_num_replc;
        st_inv    = 1'b1;
        timer_clr = 1'b1;
        state_d   = ST_FILL;
      end
      ST_FILL: begin
        timer_inc = 1'b1;
        if (fill_done) begin
          st_wr   = 1'b1;
          flag_ld = 1'b1;
          state_d = ST_RESP;
        end else if (timer_q == TMO_LAST) begin
          flag_ld = 1'b1;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath registers: request tag, victim, response flags, timer, pending flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q        <= '0;
      victim_q     <= '0;
      hit_q        <= 1'b0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      timer_q      <= '0;
    end else begin
      flush_pend_q <= flush_pend_d;
      if (tag_ld) begin
        tag_q <= req_tag;
      end
      if (victim_ld) begin
        victim_q <= victim_d;
      end
      if (flag_ld) begin
        hit_q <= hit_d;
        err_q <= err_d;
      end
      if (timer_clr) begin
        timer_q <= '0;
      end else if (timer_inc) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_hit   = rsp_valid && hit_q;
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_buf   = rsp_valid ? victim_q : '0;

  assign fill_req  = (state_q == ST_FILL);
  assign fill_buf  = fill_req ? victim_q : '0;
  assign fill_tag  = fill_req ? tag_q : '0;

endmodule

// File: tb/tb_buf_alloc_ctrl.sv
// Self-checking bench for buf_alloc_ctrl with a tag-store reference model
// and a registered LFU finder stand-in.
module tb_buf_alloc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [7:0] req_tag;
  logic       req_ready;
  logic       flush;
  logic       rsp_valid, rsp_hit, rsp_err;
  logic [1:0] rsp_buf;
  logic       lfu_new_buf_req, lfu_ref_vld;
  logic [1:0] lfu_ref_buf_numbr;
  logic [1:0] lfu_buf_num_replc;
  logic       fill_req;
  logic [1:0] fill_buf;
  logic [7:0] fill_tag;
  logic       fill_done;

  logic [1:0] lfu_pick;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference tag store
  bit         mvalid [4];
  logic [7:0] mtag   [4];

  always #5 clk = ~clk;

  buf_alloc_ctrl #(
    .TAG_W (8),
    .LEN   (2),
    .TMO_W (4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_tag           (req_tag),
    .req_ready         (req_ready),
    .flush             (flush),
    .rsp_valid         (rsp_valid),
    .rsp_hit           (rsp_hit),
    .rsp_err           (rsp_err),
    .rsp_buf           (rsp_buf),
    .lfu_new_buf_req   (lfu_new_buf_req),
    .lfu_ref_vld       (lfu_ref_vld),
    .lfu_ref_buf_numbr (lfu_ref_buf_numbr),
    .lfu_buf_num_replc (lfu_buf_num_replc),
    .fill_req          (fill_req),
    .fill_buf          (fill_buf),
    .fill_tag          (fill_tag),
    .fill_done         (fill_done)
  );

  // Finder stand-in: registers the chosen victim when pulsed.
  always @(posedge clk) begin
    if (!rst_n) lfu_buf_num_replc <= 2'd0;
    else if (lfu_new_buf_req) lfu_buf_num_replc <= lfu_pick;
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mvalid[i] = 1'b0;
  endtask

  // One full request. fd: FILL cycle in which fill_done is driven (0 = never).
  task automatic txn(input logic [7:0] t, input int fd, input logic [1:0] pick, input bit fl);
    int  hi, fr, v, nf;
    bit  fl_eff;
    hi = -1; fr = -1;
    for (int i = 0; i < 4; i++) begin
      if (hi < 0 && mvalid[i] && mtag[i] == t) hi = i;
      if (fr < 0 && !mvalid[i]) fr = i;
    end
    fl_eff = fl && (hi < 0);
    lfu_pick = pick;

    @(negedge clk); req_valid = 1'b1; req_tag = t; #1;
    chk("ready_idle", 32'(req_ready), 32'd1);

    @(negedge clk); req_valid = 1'b0; req_tag = 8'($urandom); fill_done = 1'($urandom); #1;
    chk("ready_busy", 32'(req_ready), 32'd0);
    chk("ref_vld", 32'(lfu_ref_vld), 32'(hi >= 0));
    if (hi >= 0) chk("ref_num", 32'(lfu_ref_buf_numbr), 32'(hi));
    else chk("ref_num_idle", 32'(lfu_ref_buf_numbr), 32'd0);
    chk("new_buf_req", 32'(lfu_new_buf_req), 32'(hi < 0 && fr < 0));

    if (hi >= 0) v = hi;
    else if (fr >= 0) v = fr;
    else begin
      @(negedge clk); fill_done = 1'($urandom); #1;
      chk("new_buf_req_width", 32'(lfu_new_buf_req), 32'd0);
      chk("fill_req_evict", 32'(fill_req), 32'd0);
      v = int'(pick);
      mvalid[v] = 1'b0;
    end

    if (hi < 0) begin
      nf = (fd > 0) ? fd : 15;
      for (int k = 1; k <= nf; k++) begin
        @(negedge clk); fill_done = (k == fd); flush = fl_eff && (k == 1); #1;
        chk("fill_req", 32'(fill_req), 32'd1);
        chk("fill_buf", 32'(fill_buf), 32'(v));
        chk("fill_tag", 32'(fill_tag), 32'(t));
        chk("rsp_in_fill", 32'(rsp_valid), 32'd0);
      end
      if (fd > 0) begin
        mvalid[v] = 1'b1;
        mtag[v]   = t;
      end
    end

    @(negedge clk); fill_done = 1'b0; flush = 1'b0; #1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_hit", 32'(rsp_hit), 32'(hi >= 0));
    chk("rsp_err", 32'(rsp_err), 32'(hi < 0 && fd == 0));
    chk("rsp_buf", 32'(rsp_buf), 32'(v));
    chk("fill_req_resp", 32'(fill_req), 32'd0);

    @(negedge clk); #1;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    chk("ready_after", 32'(req_ready), 32'(!fl_eff));
    if (fl_eff) begin
      model_clear();
      @(negedge clk); #1;
      chk("ready_post_flush", 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_tag = 8'h00; flush = 1'b0;
    fill_done = 1'b0; lfu_pick = 2'd0;
    model_clear();
    for (int i = 0; i < 4; i++) mtag[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp", 32'({rsp_valid, rsp_hit, rsp_err, rsp_buf}), 32'd0);
    chk("rst_lfu", 32'({lfu_new_buf_req, lfu_ref_vld, lfu_ref_buf_numbr}), 32'd0);
    chk("rst_fill", 32'({fill_req, fill_buf, fill_tag}), 32'd0);
    rst_n = 1'b1;

    // Miss into buffer 0, then hit
    txn(8'h11, 4, 2'd0, 1'b0);
    txn(8'h11, 4, 2'd0, 1'b0);

    // Fill remaining buffers, force an eviction of buffer 2, then 0x33 misses
    txn(8'h22, 1, 2'd0, 1'b0);
    txn(8'h33, 7, 2'd0, 1'b0);
    txn(8'h44, 15, 2'd0, 1'b0);
    txn(8'h55, 2, 2'd2, 1'b0);
    txn(8'h33, 3, 2'd1, 1'b0);

    // Timeout leaves the evicted entry invalid; same tag misses again
    txn(8'h66, 0, 2'd3, 1'b0);
    txn(8'h66, 5, 2'd0, 1'b0);

    // Flush during FILL is deferred to IDLE; resident tag then misses
    txn(8'h77, 5, 2'd0, 1'b1);
    txn(8'h11, 2, 2'd0, 1'b0);

    // Reset in the middle of a fill
    @(negedge clk); req_valid = 1'b1; req_tag = 8'h22; #1;
    @(negedge clk); req_valid = 1'b0; #1;
    @(negedge clk); #1;
    chk("pre_rst_fill", 32'(fill_req), 32'd1);
    @(negedge clk); rst_n = 1'b0; #1;
    @(negedge clk); #1;
    chk("rst_fill_drop", 32'(fill_req), 32'd0);
    chk("rst_rsp_none", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk); fill_done = 1'b1; #1;
    chk("stray_done_ready", 32'(req_ready), 32'd1);
    chk("stray_done_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk); fill_done = 1'b0; #1;
    chk("stray_done_fill", 32'(fill_req), 32'd0);
    chk("stray_done_rsp2", 32'(rsp_valid), 32'd0);
    txn(8'h11, 2, 2'd0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [7:0] t;
      int         fd;
      t  = 8'(8'h11 * $urandom_range(1, 6));
      fd = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15));
      txn(t, fd, 2'($urandom), ($urandom_range(0, 5) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
